// File: rtl/sc_fifo_rd_width_conv_if.sv
// Read-side bus of the FIFO width converter: the FIFO show-ahead port on one
// side, the narrow valid/ready beat stream on the other. Signal suffixes are
// from the converter's point of view.
interface sc_fifo_rd_width_conv_if #(
  parameter int DATA_W = 256,
  parameter int OUT_W  = 32
);
  logic [DATA_W-1:0] fifo_data_i;
  logic              fifo_empty_i;
  logic              fifo_rd_en_o;
  logic              flush_i;
  logic [OUT_W-1:0]  data_o;
  logic              valid_o;
  logic              ready_i;
  logic              last_beat_o;

  // Environment side: models the FIFO and the narrow consumer.
  modport master (
    output fifo_data_i, fifo_empty_i, flush_i, ready_i,
    input  fifo_rd_en_o, data_o, valid_o, last_beat_o
  );

  // Converter side.
  modport slave (
    input  fifo_data_i, fifo_empty_i, flush_i, ready_i,
    output fifo_rd_en_o, data_o, valid_o, last_beat_o
  );
endinterface

// File: rtl/sc_fifo_rd_width_conv.sv
// Read-side width converter: pops DATA_W words from a show-ahead FIFO and
// streams them out as RATIO = DATA_W/OUT_W beats, least-significant slice
// first. A new word is popped in the same cycle the last beat of the previous
// one is accepted, so the output runs at one beat per clock across words.
module sc_fifo_rd_width_conv #(
  parameter int DATA_W = 256,
  parameter int OUT_W  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  sc_fifo_rd_width_conv_if.slave        bus
);

  localparam int RATIO = DATA_W / OUT_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hold_valid_q, hold_valid_d;

  logic last_beat;
  logic fire;
  logic last_fire;
  logic pop;

  // Handshake decode; pop is combinational from ready_i so that the next word
  // is fetched in the same cycle the final slice leaves.
  always_comb begin
    last_beat = hold_valid_q & (cnt_q == CNT_LAST);
    fire      = hold_valid_q & bus.ready_i;
    last_fire = fire & last_beat;
    pop       = ~bus.fifo_empty_i & ~bus.flush_i & ~rst_i &
                (~hold_valid_q | last_fire);
  end

  assign bus.data_o       = hold_q[OUT_W-1:0];
  assign bus.valid_o      = hold_valid_q;
  assign bus.last_beat_o  = last_beat;
  assign bus.fifo_rd_en_o = pop;

  // Next-state selection: flush beats pop, pop beats a plain beat advance.
  // The hold register is left alone on flush; its content is don't-care
  // while hold_valid is low.
  always_comb begin
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    hold_valid_d = hold_valid_q;
    if (bus.flush_i) begin
      hold_valid_d = 1'b0;
      cnt_d        = '0;
    end else if (pop) begin
      hold_d       = bus.fifo_data_i;
      cnt_d        = '0;
      hold_valid_d = 1'b1;
    end else if (last_fire) begin
      hold_valid_d = 1'b0;
      cnt_d        = '0;
    end else if (fire) begin
      hold_d       = hold_q >> OUT_W;
      cnt_d        = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset also clears the data hold so data_o reads zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q       <= '0;
      cnt_q        <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      hold_valid_q <= hold_valid_d;
    end
  end

endmodule

// File: tb/tb_sc_fifo_rd_width_conv.sv
// Bench for sc_fifo_rd_width_conv: a 32->8 instance checked every cycle
// against a queue-of-beats reference model under directed and random
// stimulus, plus a 16->16 pass-through instance with literal expectations.
module tb_sc_fifo_rd_width_conv;

  localparam int A_DW = 32;
  localparam int A_OW = 8;
  localparam int A_R  = A_DW / A_OW;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  sc_fifo_rd_width_conv_if #(.DATA_W(A_DW), .OUT_W(A_OW)) bus_a ();
  sc_fifo_rd_width_conv_if #(.DATA_W(16),   .OUT_W(16))   bus_b ();

  sc_fifo_rd_width_conv #(.DATA_W(A_DW), .OUT_W(A_OW)) u_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (bus_a)
  );

  sc_fifo_rd_width_conv #(.DATA_W(16), .OUT_W(16)) u_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A: FIFO, reference model, observations -------
  logic [A_DW-1:0] fifo_a[$];
  logic [A_OW-1:0] cur[$];      // remaining beats of the word being emitted
  bit              zero_hold;   // nothing loaded since reset: data_o reads 0
  bit              pop_pend;
  int              cyc = 0;

  logic [A_OW-1:0] acc[$];      // beats actually transferred by the DUT
  int              acc_lastmask;
  int              pops;
  int              popc[$];
  logic            ov, ol, ore;
  logic [A_OW-1:0] od;

  task automatic clear_obs();
    acc.delete();
    popc.delete();
    acc_lastmask = 0;
    pops = 0;
  endtask

  task automatic cycle_a(input bit r, input bit f, input bit rs);
    bit ev, el, er;
    logic [A_OW-1:0] ed;
    @(posedge clk); #1;
    if (pop_pend) void'(fifo_a.pop_front());
    pop_pend = 0;
    bus_a.fifo_empty_i = (fifo_a.size() == 0);
    bus_a.fifo_data_i  = (fifo_a.size() != 0) ? fifo_a[0] : '0;
    bus_a.ready_i      = r;
    bus_a.flush_i      = f;
    rst_a              = rs;
    @(negedge clk);
    cyc++;
    // Expected outputs from the model
    ev = (cur.size() != 0);
    ed = ev ? cur[0] : '0;
    el = (cur.size() == 1);
    er = (fifo_a.size() != 0) && !f && !rs && (!ev || (r && el));
    chk("valid_o", bus_a.valid_o, ev);
    chk("last_beat_o", bus_a.last_beat_o, el);
    chk("fifo_rd_en_o", bus_a.fifo_rd_en_o, er);
    if (ev || zero_hold) chk("data_o", bus_a.data_o, ed);
    // Observations
    ov = bus_a.valid_o; od = bus_a.data_o; ol = bus_a.last_beat_o; ore = bus_a.fifo_rd_en_o;
    if (ov && r && !f && !rs) begin
      if (ol) acc_lastmask |= (1 << acc.size());
      acc.push_back(od);
    end
    if (ore) begin pops++; popc.push_back(cyc); end
    // Model update for the coming edge
    if (rs) begin
      cur.delete(); zero_hold = 1;
    end else if (f) begin
      cur.delete();
    end else if (er) begin
      cur.delete();
      for (int i = 0; i < A_R; i++) cur.push_back(A_OW'(fifo_a[0] >> (i * A_OW)));
      zero_hold = 0;
      pop_pend = 1;
    end else if (ev && r) begin
      void'(cur.pop_front());
    end
  endtask

  task automatic chk_seq(input string name, input logic [A_OW-1:0] exp[$]);
    chk({name, "_count"}, acc.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(name, (i < acc.size()) ? acc[i] : 'hDEAD, exp[i]);
  endtask

  // ---------------- instance B: pass-through ------------------------------
  logic [15:0] fifo_b[$];
  bit          pop_b;

  task automatic cycle_b(input bit r);
    @(posedge clk); #1;
    if (pop_b) void'(fifo_b.pop_front());
    bus_b.fifo_empty_i = (fifo_b.size() == 0);
    bus_b.fifo_data_i  = (fifo_b.size() != 0) ? fifo_b[0] : '0;
    bus_b.ready_i      = r;
    bus_b.flush_i      = 1'b0;
    @(negedge clk);
    pop_b = bus_b.fifo_rd_en_o;
  endtask

  initial begin
    logic [A_OW-1:0] e[$];
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bus_a.fifo_empty_i = 1'b1; bus_a.fifo_data_i = '0;
    bus_a.ready_i = 1'b0;      bus_a.flush_i = 1'b0;
    bus_b.fifo_empty_i = 1'b1; bus_b.fifo_data_i = '0;
    bus_b.ready_i = 1'b0;      bus_b.flush_i = 1'b0;
    zero_hold = 1; pop_pend = 0; pop_b = 0;

    // Reset state
    repeat (3) cycle_a(1, 0, 1);
    cycle_a(1, 0, 0);
    chk("reset_valid", ov, 0); chk("reset_data", od, 0);
    chk("reset_last", ol, 0);  chk("reset_rd_en", ore, 0);

    // Single word, ready high
    clear_obs();
    fifo_a.push_back(32'h44332211);
    repeat (7) cycle_a(1, 0, 0);
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk_seq("single_word", e);
    chk("single_lastmask", acc_lastmask, 32'h8);
    chk("single_pops", pops, 1);

    // Two words back to back
    clear_obs();
    fifo_a.push_back(32'h44332211); fifo_a.push_back(32'h88776655);
    repeat (12) cycle_a(1, 0, 0);
    e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    chk_seq("two_words", e);
    chk("two_lastmask", acc_lastmask, 32'h88);
    chk("two_pops", pops, 2);
    chk("two_pop_spacing", (popc.size() == 2) ? popc[1] - popc[0] : -1, 4);

    // Same words, stalling consumer
    clear_obs();
    fifo_a.push_back(32'h44332211); fifo_a.push_back(32'h88776655);
    for (int k = 0; k < 30; k++) cycle_a(pat[k % 6], 0, 0);
    chk_seq("stall_words", e);
    chk("stall_lastmask", acc_lastmask, 32'h88);
    chk("stall_pops", pops, 2);

    // Flush after 0x22 accepted
    clear_obs();
    fifo_a.push_back(32'h44332211); fifo_a.push_back(32'h88776655);
    repeat (3) cycle_a(1, 0, 0);
    cycle_a(1, 1, 0);
    chk("flush_rd_en", ore, 0);
    cycle_a(1, 0, 0);
    chk("after_flush_valid", ov, 0);
    repeat (7) cycle_a(1, 0, 0);
    e = '{8'h11, 8'h22, 8'h55, 8'h66, 8'h77, 8'h88};
    chk_seq("flush_words", e);
    chk("flush_lastmask", acc_lastmask, 32'h20);

    // Reset while the last beat is presented with the next word waiting
    clear_obs();
    fifo_a.push_back(32'h44332211); fifo_a.push_back(32'h88776655);
    repeat (4) cycle_a(1, 0, 0);
    cycle_a(1, 0, 1);
    chk("rst_mid_rd_en", ore, 0);
    chk("rst_mid_last_shown", ol, 1);
    cycle_a(1, 0, 0);
    chk("post_rst_valid", ov, 0); chk("post_rst_data", od, 0);
    chk("post_rst_last", ol, 0);  chk("post_rst_rd_en", ore, 1);
    repeat (6) cycle_a(1, 0, 0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if (fifo_a.size() < 4 && $urandom_range(0, 9) < 4) fifo_a.push_back($urandom);
      cycle_a($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2);
    end
    repeat (12) cycle_a(1, 0, 0);

    // Pass-through instance
    rst_b = 1'b1;
    repeat (2) cycle_b(1);
    rst_b = 1'b0;
    fifo_b.push_back(16'hAAAA); fifo_b.push_back(16'hBBBB);
    cycle_b(1);
    chk("pt_c0_valid", bus_b.valid_o, 0); chk("pt_c0_rd_en", bus_b.fifo_rd_en_o, 1);
    cycle_b(1);
    chk("pt_c1_valid", bus_b.valid_o, 1); chk("pt_c1_data", bus_b.data_o, 16'hAAAA);
    chk("pt_c1_last", bus_b.last_beat_o, 1); chk("pt_c1_rd_en", bus_b.fifo_rd_en_o, 1);
    cycle_b(1);
    chk("pt_c2_valid", bus_b.valid_o, 1); chk("pt_c2_data", bus_b.data_o, 16'hBBBB);
    chk("pt_c2_last", bus_b.last_beat_o, 1); chk("pt_c2_rd_en", bus_b.fifo_rd_en_o, 0);
    cycle_b(1);
    chk("pt_c3_valid", bus_b.valid_o, 0); chk("pt_c3_last", bus_b.last_beat_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_fifo_rd_width_conv.md
# sc_fifo_rd_width_conv

Downstream read-side stage for the single-clock FIFO: drains DATA_W-wide words from the FIFO's show-ahead read port (data/empty/rd_en) and emits them as a narrower OUT_W valid/ready stream, least-significant slice first. Sustains one output beat per clock, including across word boundaries. Sits between the FIFO and any narrow consumer (serializer, register bus, MAC lane).

## Interface
- DATA_W, 256: FIFO word width; must be an integer multiple of OUT_W.
- OUT_W, 32: output beat width; RATIO = DATA_W/OUT_W beats per word, RATIO >= 1.
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- fifo_data_i  in  DATA_W  FIFO head word; valid whenever fifo_empty_i = 0.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rd_en_o  out  1  pop strobe to FIFO; head advances at the same edge.
- flush_i  in  1  drop the word currently being sliced.
- data_o  out  OUT_W  current beat.
- valid_o  out  1  beat valid.
- ready_i  in  1  consumer accepts beat when valid_o & ready_i.
- last_beat_o  out  1  current beat is the final slice (index RATIO-1) of its word.

## Operation
- State: hold register (DATA_W), beat counter cnt (max(1,$clog2(RATIO)) bits), hold_valid flag.
- data_o = hold[OUT_W-1:0]; valid_o = hold_valid; last_beat_o = hold_valid & (cnt == RATIO-1).
- fire = valid_o & ready_i; last_fire = fire & last_beat_o.
- fifo_rd_en_o = !fifo_empty_i & !flush_i & !rst_i & (!hold_valid | last_fire). Combinational from ready_i; never asserted while fifo_empty_i = 1.
- Priority per edge: rst_i > flush_i > pop > beat advance.
- Pop (fifo_rd_en_o = 1): hold <= fifo_data_i, cnt <= 0, hold_valid <= 1.
- fire without last: hold <= hold >> OUT_W, cnt <= cnt + 1.
- last_fire without pop: hold_valid <= 0, cnt <= 0.
- ready_i low with valid_o high: hold, cnt, data_o, last_beat_o stable (no beat dropped or repeated).
- flush_i: hold_valid <= 0, cnt <= 0 regardless of ready_i; beat presented that cycle counts as not transferred; no pop that cycle; FIFO contents untouched.
- RATIO = 1: pass-through; last_beat_o = valid_o; pop on every fire when FIFO non-empty.
- cnt never exceeds RATIO-1; shift is logical, vacated upper bits are don't-care.

## Timing
- Reset (synchronous): hold = 0, cnt = 0, hold_valid = 0 -> valid_o = 0, data_o = 0, last_beat_o = 0, fifo_rd_en_o = 0 while rst_i high.
- Latency: fifo_empty_i falls in cycle N with stage idle -> fifo_rd_en_o = 1 in N -> valid_o = 1, data_o = slice 0 in N+1.
- Word of RATIO beats with ready_i held high occupies exactly RATIO cycles of valid_o.
- Word boundary: last_fire in cycle M with FIFO non-empty -> pop in M -> slice 0 of next word in M+1; no bubble.
- last_fire with FIFO empty -> valid_o = 0 from M+1 until the cycle after next pop.
- Reset mid-word: partially sliced word is discarded; FIFO state is the FIFO's own responsibility.
- Simultaneous flush_i and last_fire: flush wins, no pop, valid_o = 0 next cycle.

## Test plan
- DATA_W=32, OUT_W=8, FIFO holds 0x44332211, ready_i=1 -> beats 0x11,0x22,0x33,0x44 on consecutive cycles, last_beat_o only on 0x44, exactly one fifo_rd_en_o pulse.
- Two words 0x44332211, 0x88776655 back-to-back, ready_i=1 -> 8 consecutive valid beats 0x11..0x88, last on 0x44 and 0x88, pops in cycles 0 and 4 relative to first pop.
- Same stimulus, ready_i pattern 1,0,0,1,0,1,... -> data_o holds during ready_i=0, output sequence identical, no extra pops.
- Flush after beat 0x22 accepted -> valid_o=0 next cycle, next word 0x88776655 then emitted from 0x55; 0x33/0x44 never appear.
- rst_i asserted mid-word for 1 cycle -> next cycle valid_o=0, data_o=0, last_beat_o=0, fifo_rd_en_o=0 during reset.
- DATA_W=OUT_W=16, words 0xAAAA,0xBBBB, ready_i=1 -> one beat per word, last_beat_o=1 on both, pop every cycle while non-empty.
